// File: rtl/fetch_ifid.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ifid
// Purpose  : Instruction fetch (single outstanding request) plus IF/ID register.
// Revision : 1.0
// ============================================================================
module fetch_ifid #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_done,
    input  logic [15:0] imem_data,
    input  logic        stall_id,
    input  logic        redirect,
    input  logic [15:0] redirect_target,
    input  logic        halt_id,
    output logic [15:0] Instruction,
    output logic [15:0] PC_plus_two,
    output logic        valid_id,
    output logic [15:0] PC,
    output logic        err
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_WAIT    = 3'd1,
        S_HOLD    = 3'd2,
        S_DISCARD = 3'd3,
        S_HALTED  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_pcp2;
    logic        r_valid;
    logic        r_err;
    logic        r_buf_valid;
    logic [15:0] r_buf_instr;
    logic [15:0] r_buf_pcp2;
    logic        r_pending;
    logic        r_stale;

    logic [15:0] w_pc_inc;
    logic [15:0] w_pc_nxt;
    logic        w_halted;
    logic        w_halt_go;
    logic        w_req;
    logic        w_ifid_ld;
    logic [15:0] w_ifid_instr;
    logic [15:0] w_ifid_pcp2;
    logic        w_flush;
    logic        w_buf_ld;
    logic        w_buf_clr;
    logic        w_err_set;

    assign w_pc_inc  = r_pc + 16'd2;
    assign w_halted  = (r_state == S_HALTED);
    assign w_halt_go = halt_id && !stall_id && !redirect && !w_halted;
    assign w_req     = (r_state == S_FETCH) && !stall_id && !r_buf_valid && !w_halt_go;

    // A done with nothing outstanding is a protocol error, except for the
    // leftover response of a request issued before the last reset.
    // $isunknown only has an effect in four-state simulation.
    assign w_err_set = (imem_done && !r_pending && !w_req && !r_stale)
                     || (redirect && !w_halted && redirect_target[0])
                     || (imem_done && $isunknown(imem_data));

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ifid_ld    = 1'b0;
        w_ifid_instr = imem_data;
        w_ifid_pcp2  = w_pc_inc;
        w_flush      = 1'b0;
        w_buf_ld     = 1'b0;
        w_buf_clr    = 1'b0;
        if (w_halted) begin
            w_flush   = 1'b1;
            w_buf_clr = 1'b1;
        end else if (redirect) begin
            w_flush   = 1'b1;
            w_buf_clr = 1'b1;
            w_pc_nxt  = redirect_target;
            case (r_state)
                S_FETCH:          w_state_nxt = (w_req && !imem_done) ? S_DISCARD : S_FETCH;
                S_WAIT, S_DISCARD: w_state_nxt = imem_done ? S_FETCH : S_DISCARD;
                default:          w_state_nxt = S_FETCH;
            endcase
        end else if (w_halt_go) begin
            w_flush     = 1'b1;
            w_buf_clr   = 1'b1;
            w_state_nxt = S_HALTED;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_req && imem_done) begin
                        w_ifid_ld = 1'b1;
                        w_pc_nxt  = w_pc_inc;
                    end else if (w_req) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_done) begin
                        w_pc_nxt = w_pc_inc;
                        if (!stall_id) begin
                            w_ifid_ld   = 1'b1;
                            w_state_nxt = S_FETCH;
                        end else begin
                            w_buf_ld    = 1'b1;
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_id) begin
                        w_ifid_ld    = 1'b1;
                        w_ifid_instr = r_buf_instr;
                        w_ifid_pcp2  = r_buf_pcp2;
                        w_buf_clr    = 1'b1;
                        w_state_nxt  = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (imem_done) begin
                        w_state_nxt = S_FETCH;
                    end
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // IF/ID register: decode consuming without a new word empties the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr <= NOP_INSTR;
            r_pcp2  <= RESET_PC + 16'd2;
            r_valid <= 1'b0;
        end else if (w_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (w_ifid_ld) begin
            r_instr <= w_ifid_instr;
            r_pcp2  <= w_ifid_pcp2;
            r_valid <= 1'b1;
        end else if (!stall_id) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_valid <= 1'b0;
            r_buf_instr <= NOP_INSTR;
            r_buf_pcp2  <= RESET_PC + 16'd2;
        end else if (w_buf_clr) begin
            r_buf_valid <= 1'b0;
        end else if (w_buf_ld) begin
            r_buf_valid <= 1'b1;
            r_buf_instr <= imem_data;
            r_buf_pcp2  <= w_pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
            r_stale   <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            if (w_req && !imem_done) begin
                r_pending <= 1'b1;
            end else if (imem_done) begin
                r_pending <= 1'b0;
            end
            if (w_req) begin
                r_stale <= 1'b0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign PC          = r_pc;
    assign Instruction = r_instr;
    assign PC_plus_two = r_pcp2;
    assign valid_id    = r_valid;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ifid.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ifid
// Purpose  : Directed self-checking bench for fetch_ifid.
// Revision : 1.0
// ============================================================================
module tb_fetch_ifid;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_done;
    logic [15:0] imem_data;
    logic        stall_id;
    logic        redirect;
    logic [15:0] redirect_target;
    logic        halt_id;
    logic [15:0] Instruction;
    logic [15:0] PC_plus_two;
    logic        valid_id;
    logic [15:0] PC;
    logic        err;

    int n_checks;
    int n_fail;

    fetch_ifid #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0800)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_done       (imem_done),
        .imem_data       (imem_data),
        .stall_id        (stall_id),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt_id         (halt_id),
        .Instruction     (Instruction),
        .PC_plus_two     (PC_plus_two),
        .valid_id        (valid_id),
        .PC              (PC),
        .err             (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic d, input logic [15:0] dat,
                         input logic r, input logic [15:0] tgt, input logic h);
        stall_id        = s;
        imem_done       = d;
        imem_data       = dat;
        redirect        = r;
        redirect_target = tgt;
        halt_id         = h;
        #1;
    endtask

    task automatic cyc(input logic s, input logic d, input logic [15:0] dat,
                       input logic r, input logic [15:0] tgt, input logic h);
        @(negedge clk);
        drive(s, d, dat, r, tgt, h);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        #1 rst = 1'b0;

        // Reset values
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("rst_pc", PC, 16'h0000);
        check("rst_instr", Instruction, 16'h0800);
        check("rst_pcp2", PC_plus_two, 16'h0002);
        check("rst_valid", 16'(valid_id), 16'd0);
        check("rst_err", 16'(err), 16'd0);

        // Back-to-back hits at 0..E
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0);
            else        cyc(1'b0, 1'b1, 16'h1000 + 16'(2 * i), 1'b0, 16'h0000, 1'b0);
            check("hit_req", 16'(imem_req), 16'd1);
            check("hit_addr", imem_addr, 16'(2 * i));
            if (i > 0) begin
                check("hit_instr", Instruction, 16'h1000 + 16'(2 * i) - 16'd2);
                check("hit_pcp2", PC_plus_two, 16'(2 * i));
                check("hit_valid", 16'(valid_id), 16'd1);
            end
        end

        // Miss at 0x0010, done three cycles after the request
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("miss_req", 16'(imem_req), 16'd1);
        check("miss_addr", imem_addr, 16'h0010);
        check("miss_last_instr", Instruction, 16'h100E);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("wait_req", 16'(imem_req), 16'd0);
        check("wait_addr", imem_addr, 16'h0010);
        check("wait_instr", Instruction, 16'h0800);
        check("wait_valid", 16'(valid_id), 16'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("wait2_req", 16'(imem_req), 16'd0);
        cyc(1'b0, 1'b1, 16'h4123, 1'b0, 16'h0000, 1'b0);
        check("wait3_req", 16'(imem_req), 16'd0);
        cyc(1'b0, 1'b1, 16'h2000, 1'b0, 16'h0000, 1'b0);
        check("miss_instr", Instruction, 16'h4123);
        check("miss_pcp2", PC_plus_two, 16'h0012);
        check("miss_valid", 16'(valid_id), 16'd1);
        check("miss_next_addr", imem_addr, 16'h0012);
        check("miss_next_req", 16'(imem_req), 16'd1);

        // Stalled return lands in the hold buffer
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("h_instr_2000", Instruction, 16'h2000);
        check("h_addr", imem_addr, 16'h0014);
        cyc(1'b1, 1'b1, 16'hC0FF, 1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("hold_instr", Instruction, 16'h0800);
        check("hold_req", 16'(imem_req), 16'd0);
        check("hold_pc", PC, 16'h0016);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("hold2_instr", Instruction, 16'h0800);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("unstall_req", 16'(imem_req), 16'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("buf_instr", Instruction, 16'hC0FF);
        check("buf_pcp2", PC_plus_two, 16'h0016);
        check("buf_valid", 16'(valid_id), 16'd1);
        check("resume_req", 16'(imem_req), 16'd1);
        check("resume_addr", imem_addr, 16'h0016);

        // Redirect while waiting: returning word is dropped
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0);
        check("redir_wait_req", 16'(imem_req), 16'd0);
        cyc(1'b0, 1'b1, 16'hDEAD, 1'b0, 16'h0000, 1'b0);
        check("redir_instr", Instruction, 16'h0800);
        check("redir_valid", 16'(valid_id), 16'd0);
        check("redir_pc", PC, 16'h0100);
        check("discard_req", 16'(imem_req), 16'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("drop_instr", Instruction, 16'h0800);
        check("drop_valid", 16'(valid_id), 16'd0);
        check("tgt_req", 16'(imem_req), 16'd1);
        check("tgt_addr", imem_addr, 16'h0100);
        check("err_clean", 16'(err), 16'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0101, 1'b0);
        cyc(1'b0, 1'b1, 16'h1111, 1'b0, 16'h0000, 1'b0);
        check("misalign_err", 16'(err), 16'd1);

        // Redirect beats a same-cycle hit; then wrap at 0xFFFE
        cyc(1'b0, 1'b1, 16'h5555, 1'b1, 16'hFFFE, 1'b0);
        check("redir_hit_addr", imem_addr, 16'h0101);
        cyc(1'b0, 1'b1, 16'h7777, 1'b0, 16'h0000, 1'b0);
        check("redir_hit_drop", Instruction, 16'h0800);
        check("wrap_addr", imem_addr, 16'hFFFE);
        cyc(1'b0, 1'b1, 16'h6666, 1'b0, 16'h0000, 1'b0);
        check("wrap_instr", Instruction, 16'h7777);
        check("wrap_pcp2", PC_plus_two, 16'h0000);
        check("wrap_next_addr", imem_addr, 16'h0000);

        // Halt
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        check("halt_req", 16'(imem_req), 16'd0);
        check("halt_prev_instr", Instruction, 16'h6666);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 16'h0000, (i == 1), 16'h0200, 1'b0);
            check("halted_req", 16'(imem_req), 16'd0);
            check("halted_instr", Instruction, 16'h0800);
            check("halted_valid", 16'(valid_id), 16'd0);
            check("halted_pc", PC, 16'h0002);
        end

        // Asynchronous reset mid-operation, then stale-done tolerance
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("arst_pc", PC, 16'h0000);
        check("arst_err", 16'(err), 16'd0);
        check("arst_instr", Instruction, 16'h0800);
        check("arst_pcp2", PC_plus_two, 16'h0002);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b1, 16'h9999, 1'b0, 16'h0000, 1'b0);
        check("stale_req", 16'(imem_req), 16'd0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("stale_err", 16'(err), 16'd0);
        cyc(1'b0, 1'b1, 16'h0ABC, 1'b0, 16'h0000, 1'b0);
        check("post_rst_addr", imem_addr, 16'h0000);
        cyc(1'b1, 1'b1, 16'h4444, 1'b0, 16'h0000, 1'b0);
        check("post_rst_instr", Instruction, 16'h0ABC);
        check("spurious_req", 16'(imem_req), 16'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("spurious_err", 16'(err), 16'd1);
        check("stall_hold_instr", Instruction, 16'h0ABC);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
